// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for a single-port data memory: round-robin with optional
// bounded burst locking, one access per two cycles, out-of-range accesses flagged as errors.
module data_mem_arbiter #(
    parameter int unsigned len_addr  = 11,
    parameter int unsigned len_data  = 16,
    parameter int unsigned ram_depth = 2048,
    parameter int unsigned max_burst = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                wr0,
    input  logic                wr1,
    input  logic                lock0,
    input  logic                lock1,
    input  logic [len_addr-1:0] addr0,
    input  logic [len_addr-1:0] addr1,
    input  logic [len_data-1:0] wdata0,
    input  logic [len_data-1:0] wdata1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [len_data-1:0] rdata0,
    output logic [len_data-1:0] rdata1,
    output logic                err0,
    output logic                err1,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [len_addr-1:0] mem_addr,
    output logic [len_data-1:0] mem_wdata,
    input  logic [len_data-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(max_burst + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                wr;
        logic                oor;
        logic [len_addr-1:0] addr;
        logic [len_data-1:0] wdata;
    } acc_t;

    state_t           state, next_state;
    acc_t             acc, next_acc;
    logic             owner, next_owner;
    logic             last_srv, next_last;
    logic             lock_lat, next_lock;
    logic [CNT_W-1:0] burst_cnt, next_cnt;
    logic             winner;
    logic [len_addr-1:0] win_addr;

    // State and latched-transaction registers; last_srv=1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            owner     <= 1'b0;
            last_srv  <= 1'b1;
            lock_lat  <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            acc       <= next_acc;
            owner     <= next_owner;
            last_srv  <= next_last;
            lock_lat  <= next_lock;
            burst_cnt <= next_cnt;
        end
    end

    // Arbitration, next-state and output decode
    always_comb begin
        next_state = state;
        next_acc   = acc;
        next_owner = owner;
        next_last  = last_srv;
        next_lock  = lock_lat;
        next_cnt   = burst_cnt;
        winner     = 1'b0;
        win_addr   = '0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        rvalid0    = 1'b0;
        rvalid1    = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        unique case (state)
            IDLE, RESP: begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
                        // A locked owner keeps the memory until its burst budget is spent
                        if (state == RESP && lock_lat) begin
                            winner = (burst_cnt >= CNT_W'(max_burst)) ? ~owner : owner;
                        end else begin
                            winner = ~last_srv;
                        end
                    end else begin
                        winner = req1;
                    end

                    win_addr        = winner ? addr1 : addr0;
                    next_acc.wr     = winner ? wr1 : wr0;
                    next_acc.addr   = win_addr;
                    next_acc.wdata  = winner ? wdata1 : wdata0;
                    next_acc.oor    = (32'(win_addr) >= ram_depth);
                    next_lock       = winner ? lock1 : lock0;
                    next_owner      = winner;
                    next_last       = winner;
                    if (winner != owner || burst_cnt == '0) begin
                        next_cnt = CNT_W'(1);
                    end else if (burst_cnt < CNT_W'(max_burst)) begin
                        next_cnt = burst_cnt + CNT_W'(1);
                    end
                    next_state = ACCESS;
                end else begin
                    next_state = IDLE;
                end

                if (state == RESP) begin
                    if (acc.oor) begin
                        err0 = ~owner;
                        err1 = owner;
                    end else if (!acc.wr) begin
                        rvalid0 = ~owner;
                        rvalid1 = owner;
                    end
                end
            end
            ACCESS: begin
                gnt0      = ~owner;
                gnt1      = owner;
                mem_addr  = acc.addr;
                mem_wdata = acc.wdata;
                mem_rd    = ~acc.oor & ~acc.wr;
                mem_wr    = ~acc.oor & acc.wr;
                next_state = RESP;
            end
            default: next_state = IDLE;
        endcase

        rdata0 = rvalid0 ? mem_rdata : '0;
        rdata1 = rvalid1 ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural one-cycle-latency memory.
module tb_data_mem_arbiter;

    localparam int unsigned LA = 12;
    localparam int unsigned LD = 16;

    logic          clk;
    logic          reset;
    logic          req0, req1, wr0, wr1, lock0, lock1;
    logic [LA-1:0] addr0, addr1;
    logic [LD-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [LD-1:0] rdata0, rdata1;
    logic          mem_rd, mem_wr;
    logic [LA-1:0] mem_addr;
    logic [LD-1:0] mem_wdata;
    logic [LD-1:0] mem_rdata;

    logic [LD-1:0] mem [0:2047];
    logic          pre_we;
    logic [10:0]   pre_addr;
    logic [LD-1:0] pre_data;

    logic [11:0]   outs;

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(
        .len_addr (LA),
        .len_data (LD),
        .ram_depth(2048),
        .max_burst(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .lock0    (lock0),
        .lock1    (lock1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_rd
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (mem_wr) mem[mem_addr[10:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[10:0]];
    end

    assign outs = {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_rd, mem_wr,
                   |rdata0, |rdata1, |mem_addr, |mem_wdata};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Assert reset for two cycles, release on a falling edge
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        mem_rdata = '0;
        clear_inputs();
        #3 reset = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'(outs), 32'h0);

        pre_addr = 11'h010; pre_data = 16'h1234; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_outs", 32'(outs), 32'h0);

        // Single read from requester 0
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h010;
        @(negedge clk);
        check("rd_gnt", 32'({gnt1, gnt0}), 32'h1);
        check("rd_strobe", 32'({mem_wr, mem_rd}), 32'h1);
        check("rd_addr", 32'(mem_addr), 32'h010);
        req0 = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 32'({rvalid1, rvalid0}), 32'h1);
        check("rd_rdata", 32'(rdata0), 32'h1234);
        @(negedge clk);
        check("rd_back_idle", 32'(outs), 32'h0);

        // Write from requester 1, read back by requester 0
        req1 = 1'b1; wr1 = 1'b1; addr1 = 12'h005; wdata1 = 16'h00AA;
        @(negedge clk);
        check("wr_gnt", 32'({gnt1, gnt0}), 32'h2);
        check("wr_strobe", 32'({mem_wr, mem_rd}), 32'h2);
        check("wr_addr", 32'(mem_addr), 32'h005);
        check("wr_wdata", 32'(mem_wdata), 32'h00AA);
        req1 = 1'b0; wr1 = 1'b0;
        @(negedge clk);
        check("wr_resp", 32'({err1, rvalid1, rvalid0}), 32'h0);
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h005;
        @(negedge clk);
        check("rb_gnt", 32'({gnt1, gnt0}), 32'h1);
        req0 = 1'b0;
        @(negedge clk);
        check("rb_rvalid", 32'(rvalid0), 32'h1);
        check("rb_rdata", 32'(rdata0), 32'h00AA);
        @(negedge clk);

        // Out-of-range write from requester 1
        req1 = 1'b1; wr1 = 1'b1; addr1 = 12'h800; wdata1 = 16'h0055;
        @(negedge clk);
        check("oor_gnt", 32'({gnt1, gnt0}), 32'h2);
        check("oor_strobe", 32'({mem_wr, mem_rd}), 32'h0);
        req1 = 1'b0; wr1 = 1'b0;
        @(negedge clk);
        check("oor_resp", 32'({err1, err0, rvalid1, rvalid0}), 32'h8);
        @(negedge clk);

        // Address boundary reads from requester 0: {addr, expected oor}
        begin
            logic [LA-1:0] ba [3];
            logic          bo [3];
            ba[0] = 12'h7FF; bo[0] = 1'b0;
            ba[1] = 12'h800; bo[1] = 1'b1;
            ba[2] = 12'hFFF; bo[2] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                req0 = 1'b1; wr0 = 1'b0; addr0 = ba[k];
                @(negedge clk);
                check($sformatf("bnd_rd%0d", k), 32'(mem_rd), 32'(!bo[k]));
                req0 = 1'b0;
                @(negedge clk);
                check($sformatf("bnd_resp%0d", k), 32'({err0, rvalid0}), bo[k] ? 32'h2 : 32'h1);
                @(negedge clk);
            end
        end

        // Continuous contention without lock: grants alternate 0,1,0,1
        clear_inputs();
        reset = 1'b0;
        req0 = 1'b1; addr0 = 12'h010;
        req1 = 1'b1; addr1 = 12'h020;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i % 2 == 1)
                check($sformatf("rr_c%0d", i), 32'({gnt1, gnt0}), (((i - 1) / 2) % 2 == 0) ? 32'h1 : 32'h2);
            else
                check($sformatf("rr_c%0d", i), 32'({gnt1, gnt0}), 32'h0);
        end

        // Locked burst from requester 0: 8 grants, then requester 1, then 0
        clear_inputs();
        reset = 1'b0;
        req0 = 1'b1; lock0 = 1'b1; addr0 = 12'h010;
        req1 = 1'b1; addr1 = 12'h020;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i % 2 == 1)
                check($sformatf("lk_c%0d", i), 32'({gnt1, gnt0}), ((i - 1) / 2 == 8) ? 32'h2 : 32'h1);
            else
                check($sformatf("lk_c%0d", i), 32'({gnt1, gnt0}), 32'h0);
        end

        // Reset asserted during ACCESS aborts the transaction
        clear_inputs();
        do_reset();
        req0 = 1'b1; wr0 = 1'b0; addr0 = 12'h010;
        @(negedge clk);
        check("ab_gnt", 32'({gnt1, gnt0, mem_rd}), 32'h3);
        reset = 1'b0;
        #1;
        check("ab_outs_now", 32'(outs), 32'h0);
        clear_inputs();
        @(negedge clk);
        check("ab_outs_held", 32'(outs), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("ab_after_rel", 32'(outs), 32'h0);
        req0 = 1'b1; addr0 = 12'h010;
        req1 = 1'b1; addr1 = 12'h020;
        @(negedge clk);
        check("ab_first_tie", 32'({gnt1, gnt0}), 32'h1);
        clear_inputs();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
